// File: rtl/cir_oscl_pkg.sv
// Shared state type and width for the cir_oscl oscillator.
package cir_oscl_pkg;

  localparam int unsigned STATE_W = 2;

  // 2'b11 is unused and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    CASE1 = 2'b01,
    CASE2 = 2'b10
  } state_t;

endpackage

// File: rtl/cir_oscl.sv
// Moore toggle generator: once armed by A, each A=1 edge flips between CASE1 and CASE2.
// state | meaning
// IDLE  | after reset, waiting for first A=1; y=0
// CASE1 | oscillating, high phase; y=1
// CASE2 | oscillating, low phase; y=0
module cir_oscl
  import cir_oscl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A,
  output logic y
);

  state_t r_state;
  state_t w_next;
  logic   w_y;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    w_y    = 1'b0;
    case (r_state)
      IDLE:    w_next = A ? CASE1 : IDLE;
      CASE1: begin
        w_y    = 1'b1;
        w_next = A ? CASE2 : CASE1;
      end
      CASE2:   w_next = A ? CASE1 : CASE2;
      default: w_next = IDLE;
    endcase
  end

  assign y = w_y;

endmodule

// File: tb/tb_cir_oscl.sv
// Self-checking bench for cir_oscl against a count-of-advances reference model.
module tb_cir_oscl;
  import cir_oscl_pkg::*;

  logic clk;
  logic rst;
  logic A;
  logic y;

  int checks   = 0;
  int failures = 0;

  // Model: number of A=1 edges since the last reset; odd count means the high phase.
  int n_adv = 0;

  cir_oscl dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_y();
    return (n_adv > 0) && (n_adv % 2 == 1);
  endfunction

  function automatic logic [1:0] model_state();
    if (n_adv == 0)         return 2'b00;
    else if (n_adv % 2 == 1) return 2'b01;
    else                     return 2'b10;
  endfunction

  task automatic check_y(input string tag, input logic exp);
    checks++;
    assert (y === exp) else begin
      failures++;
      $error("FAIL %s y=%0b expected=%0b", tag, y, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    checks++;
    assert (dut.r_state === exp) else begin
      failures++;
      $error("FAIL %s state=%0b expected=%0b", tag, dut.r_state, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, update the model, compare.
  task automatic step(input logic a, input logic r, input string tag);
    @(negedge clk);
    A   = a;
    rst = r;
    @(posedge clk);
    #1;
    if (r === 1'b1)      n_adv = 0;
    else if (a === 1'b1) n_adv++;
    check_y(tag, model_y());
    check_state(tag, model_state());
  endtask

  task automatic step_noref(input logic a, input logic r, input logic exp_y_v, input string tag);
    step(a, r, tag);
    check_y({tag, "_abs"}, exp_y_v);
  endtask

  initial begin
    logic [5:0] alt_a;
    logic [5:0] alt_y;
    logic [4:0] tog_y;
    A   = 1'b0;
    rst = 1'b1;

    // Reset with A unknown, then idle with A=0.
    step_noref(1'bx, 1'b1, 1'b0, "rst_ax0");
    step_noref(1'bx, 1'b1, 1'b0, "rst_ax1");
    for (int i = 0; i < 3; i++) step_noref(1'b0, 1'b0, 1'b0, "idle_hold");

    // Arm and toggle: y = 1,0,1,0,1.
    tog_y = 5'b10101;
    for (int i = 0; i < 5; i++) step_noref(1'b1, 1'b0, tog_y[4-i], "toggle");

    // Move to CASE2, hold there, then advance.
    step_noref(1'b1, 1'b0, 1'b0, "to_case2");
    for (int i = 0; i < 3; i++) step_noref(1'b0, 1'b0, 1'b0, "hold_case2");
    step_noref(1'b1, 1'b0, 1'b1, "leave_case2");
    for (int i = 0; i < 2; i++) step_noref(1'b0, 1'b0, 1'b1, "hold_case1");

    // Alternating A from IDLE: y = 0,1,1,0,0,1.
    step_noref(1'b0, 1'b1, 1'b0, "alt_rst");
    alt_a = 6'b010101;
    alt_y = 6'b011001;
    for (int i = 0; i < 6; i++) step_noref(alt_a[5-i], 1'b0, alt_y[5-i], "alternate");

    // Mid-run reset while in CASE1 with A=1, then re-arm.
    step_noref(1'b1, 1'b1, 1'b0, "midrun_rst");
    step_noref(1'b1, 1'b0, 1'b1, "rearm");
    step_noref(1'b0, 1'b1, 1'b0, "rst_again");
    step_noref(1'b0, 1'b0, 1'b0, "need_a_to_arm");

    // Illegal encoding: output low and next state IDLE for either A.
    for (int a = 0; a < 2; a++) begin
      @(negedge clk);
      A = 1'(a);
      force dut.r_state = state_t'(2'b11);
      #1;
      check_y("illegal_y", 1'b0);
      checks++;
      assert (dut.w_next === IDLE) else begin
        failures++;
        $error("FAIL illegal_next next=%0b expected=00", dut.w_next);
      end
      release dut.r_state;
      step_noref(1'b0, 1'b1, 1'b0, "illegal_recover_rst");
    end

    // Randomized run with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cir_oscl.md
Name: cir_oscl

Overview:
- Small Moore state machine that, once armed, oscillates between two states, CASE1 and CASE2, under control of a single enable-like input A.
- Output y is decoded from the current state: high in CASE1, low in CASE2 and IDLE.
- Used as a simple toggle/oscillation generator gated by A, in a single clock domain.

Parameters:
- None. State encoding is fixed; see Decomposition.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
- A    input  1  advance/toggle request, sampled on the rising edge of clk.
- y    output 1  Moore output decoded from the current state.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: rst=1 at a rising edge forces state to IDLE regardless of A.
- y reads 0 from the first clock edge where rst=1 is sampled.
- States (2-bit register): IDLE=2'b00, CASE1=2'b01, CASE2=2'b10. Encoding 2'b11 is illegal.
- Transitions, evaluated at each rising edge when rst=0:
  - IDLE: A=1 -> CASE1; A=0 -> IDLE.
  - CASE1: A=1 -> CASE2; A=0 -> CASE1 (hold).
  - CASE2: A=1 -> CASE1; A=0 -> CASE2 (hold).
  - Illegal 2'b11 -> IDLE on the next edge, independent of A.
- Output decode, combinational from the state register only (Moore):
  - y=1 in CASE1.
  - y=0 in IDLE, CASE2 and the illegal state.
- Latency: a change in A sampled at edge N is reflected in y immediately after edge N. No combinational path from A to y.
- A held at 1 continuously: y toggles every clock, i.e. a square wave at clk/2 starting 1, 0, 1, ...
- A held at 0: state and y freeze.
- Reset mid-operation: rst=1 at any edge overrides A. State goes to IDLE and y=0 on that edge.
- After rst is released, an A=1 edge is required to re-enter CASE1.
- A=X/Z while rst=1: no effect; the state is IDLE.
- y has no X after the first reset edge.
- No handshake and no other outputs.

Decomposition:
- Shared package cir_oscl_pkg holds the state enum type (state_t with IDLE, CASE1, CASE2) and the 2-bit state width constant.
- Single module, no sub-modules.
- Use one sequential block for the state register (with synchronous reset) and one combinational block for next-state and output decode. The next-state block has a default branch to IDLE.

Test Plan:
- Reset: rst=1 for 2 edges with A=X -> y=0, state=IDLE. Release rst=0 with A=0 for 3 edges -> y stays 0.
- Arm and toggle: from IDLE, A=1 for 5 consecutive edges -> y after each edge = 1,0,1,0,1 (CASE1, CASE2, CASE1, CASE2, CASE1).
- Hold: in CASE2 (y=0), A=0 for 3 edges -> y stays 0. Then A=1 for one edge -> y=1.
- Alternating A=0,1,0,1,0,1 from IDLE, one value per edge -> y = 0,1,1,0,0,1.
- Mid-run reset: while toggling in CASE1 (y=1), assert rst=1 with A=1 for one edge -> y=0, state=IDLE. Release with A=1 -> y=1 next edge.
- Illegal state: force state=2'b11 -> y=0 and state=IDLE after one edge for both A=0 and A=1.
